// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - single-car motion controller: request accept, floor stepping, door dwell.
// One request at a time; IDLE accepts, MOVE steps one floor per FLOOR_TICKS, DOOR dwells DOOR_TICKS.
module elevator_car_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FW          = 3,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [FW-1:0] req_floor,
  output logic          req_ready,
  output logic          req_err,
  output logic [FW-1:0] now_floor,
  output logic [2:0]    dir,
  output logic          moving,
  output logic          door_open,
  input  logic          door_hold,
  output logic          arrived
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] DIR_UP   = 3'b100;
  localparam logic [2:0] DIR_STOP = 3'b010;
  localparam logic [2:0] DIR_DOWN = 3'b001;

  localparam logic [TW-1:0] FLOOR_RELOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_RELOAD  = TW'(DOOR_TICKS - 1);
  localparam logic [FW:0]   FLOOR_LIMIT  = (FW+1)'(FLOORS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] floor_q, floor_d;
  logic [FW-1:0] dest_q, dest_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    dir_q, dir_d;
  logic          moving_q, moving_d;
  logic          door_q, door_d;
  logic          arrived_q, arrived_d;
  logic          err_q, err_d;
  logic [FW-1:0] step_floor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dest_q    <= '0;
      timer_q   <= '0;
      dir_q     <= DIR_STOP;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      arrived_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dest_q    <= dest_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      moving_q  <= moving_d;
      door_q    <= door_d;
      arrived_q <= arrived_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dest_d     = dest_q;
    timer_d    = timer_q;
    dir_d      = dir_q;
    moving_d   = moving_q;
    door_d     = door_q;
    arrived_d  = 1'b0;
    err_d      = 1'b0;
    step_floor = dir_q[2] ? (floor_q + FW'(1)) : (floor_q - FW'(1));

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if ({1'b0, req_floor} >= FLOOR_LIMIT) begin
            err_d = 1'b1;
          end else if (req_floor == floor_q) begin
            state_d   = DOOR;
            dest_d    = req_floor;
            arrived_d = 1'b1;
            door_d    = 1'b1;
            timer_d   = DOOR_RELOAD;
          end else begin
            state_d  = MOVE;
            dest_d   = req_floor;
            timer_d  = FLOOR_RELOAD;
            moving_d = 1'b1;
            dir_d    = (req_floor > floor_q) ? DIR_UP : DIR_DOWN;
          end
        end
      end
      MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          floor_d = step_floor;
          // Arrival is judged on the floor being entered this edge, not the current one.
          if (step_floor == dest_q) begin
            state_d   = DOOR;
            moving_d  = 1'b0;
            dir_d     = DIR_STOP;
            arrived_d = 1'b1;
            door_d    = 1'b1;
            timer_d   = DOOR_RELOAD;
          end else begin
            timer_d = FLOOR_RELOAD;
          end
        end
      end
      DOOR: begin
        if (door_hold) begin
          timer_d = DOOR_RELOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = IDLE;
          door_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign req_err   = err_q;
  assign now_floor = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_q;
  assign arrived   = arrived_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - trip-level reference model bench for elevator_car_ctrl (8- and 6-floor cars).
module tb_elevator_car_ctrl;

  localparam int FT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = '0;
  logic       door_hold = 1'b0;
  logic       sel6 = 1'b0;

  logic       a_ready, a_err, a_moving, a_door, a_arrived;
  logic [2:0] a_floor, a_dir;
  logic       b_ready, b_err, b_moving, b_door, b_arrived;
  logic [2:0] b_floor, b_dir;

  logic       o_ready, o_err, o_moving, o_door, o_arrived;
  logic [2:0] o_floor, o_dir;

  int n_cmp = 0;
  int n_bad = 0;
  int mfloor [2];

  always #5 clk = ~clk;

  elevator_car_ctrl #(.FLOORS(8), .FW(3), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel6), .req_floor(req_floor), .req_ready(a_ready), .req_err(a_err),
    .now_floor(a_floor), .dir(a_dir), .moving(a_moving), .door_open(a_door),
    .door_hold(door_hold & ~sel6), .arrived(a_arrived)
  );

  elevator_car_ctrl #(.FLOORS(6), .FW(3), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel6), .req_floor(req_floor), .req_ready(b_ready), .req_err(b_err),
    .now_floor(b_floor), .dir(b_dir), .moving(b_moving), .door_open(b_door),
    .door_hold(door_hold & sel6), .arrived(b_arrived)
  );

  assign o_ready   = sel6 ? b_ready   : a_ready;
  assign o_err     = sel6 ? b_err     : a_err;
  assign o_floor   = sel6 ? b_floor   : a_floor;
  assign o_dir     = sel6 ? b_dir     : a_dir;
  assign o_moving  = sel6 ? b_moving  : a_moving;
  assign o_door    = sel6 ? b_door    : a_door;
  assign o_arrived = sel6 ? b_arrived : a_arrived;

  // One request from acceptance to return to idle. The car's expected trace follows from
  // trip length d: floor k reached after k*FT edges, door from edge A=d*FT until
  // max(A, last counted hold edge)+DT. hs/hl place a contiguous hold window relative to A.
  task automatic run_trip(input int dest, input int hs, input int hl, input bit spam, input bit noise);
    int idx, floors, start, d, a_t, close_t, e;
    bit up;
    logic [2:0] ef, edir;
    logic [4:0] eflags, oflags;
    idx     = sel6 ? 1 : 0;
    floors  = sel6 ? 6 : 8;
    start   = mfloor[idx];
    up      = dest > start;
    d       = up ? dest - start : start - dest;
    a_t     = d * FT;
    close_t = a_t + ((hl > 0) ? hs + hl - 1 : 0) + DT;
    req_floor = 3'(dest);
    req_valid = 1'b1;
    door_hold = 1'b0;
    @(posedge clk); #1;
    if (dest >= floors) begin
      req_valid = 1'b0;
      n_cmp++;
      if ({o_err, o_ready, o_moving, o_door, o_arrived, o_dir, o_floor} !== {5'b11000, 3'b010, 3'(start)}) begin
        n_bad++;
        $display("FAIL range_err dest=%0d got err=%b rdy=%b mv=%b dr=%b arr=%b dir=%b fl=%0d want err=1 rdy=1 idle fl=%0d",
                 dest, o_err, o_ready, o_moving, o_door, o_arrived, o_dir, o_floor, start);
      end
      return;
    end
    for (int t = 0; t <= close_t; t++) begin
      if (t < a_t) begin
        ef     = up ? 3'(start + t / FT) : 3'(start - t / FT);
        edir   = up ? 3'b100 : 3'b001;
        eflags = 5'b01000;
      end else if (t < close_t) begin
        ef     = 3'(dest);
        edir   = 3'b010;
        eflags = {3'b000, 1'b1, 1'b0} | {4'b0000, (t == a_t)} | 5'b00100 & 5'b00000;
        eflags = {1'b0, 1'b0, 1'b1, (t == a_t), 1'b0};
      end else begin
        ef     = 3'(dest);
        edir   = 3'b010;
        eflags = 5'b00001;
      end
      oflags = {o_err, o_moving, o_door, o_arrived, o_ready};
      n_cmp++;
      if (o_floor !== ef) begin
        n_bad++;
        $display("FAIL trip_floor %0d->%0d t=%0d got %0d want %0d", start, dest, t, o_floor, ef);
      end
      n_cmp++;
      if ({o_dir, oflags} !== {edir, eflags}) begin
        n_bad++;
        $display("FAIL trip_status %0d->%0d t=%0d got dir=%b err,mv,dr,arr,rdy=%b want dir=%b %b",
                 start, dest, t, o_dir, oflags, edir, eflags);
      end
      e = t + 1;
      req_valid = spam && (t < close_t);
      req_floor = 3'($urandom_range(0, 7));
      door_hold = (hl > 0 && e >= a_t + hs && e < a_t + hs + hl) ||
                  (noise && e <= a_t && $urandom_range(0, 1) == 1);
      if (t < close_t) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    door_hold = 1'b0;
    mfloor[idx] = dest;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_floor, a_dir, a_moving, a_door, a_arrived, a_err, a_ready} !== {3'd0, 3'b010, 5'b00001}) begin
      n_bad++;
      $display("FAIL reset_dut8 got fl=%0d dir=%b mv=%b dr=%b arr=%b err=%b rdy=%b want 0 010 0 0 0 0 1",
               a_floor, a_dir, a_moving, a_door, a_arrived, a_err, a_ready);
    end
    n_cmp++;
    if ({b_floor, b_dir, b_moving, b_door, b_arrived, b_err, b_ready} !== {3'd0, 3'b010, 5'b00001}) begin
      n_bad++;
      $display("FAIL reset_dut6 got fl=%0d dir=%b mv=%b dr=%b arr=%b err=%b rdy=%b want 0 010 0 0 0 0 1",
               b_floor, b_dir, b_moving, b_door, b_arrived, b_err, b_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mfloor[0] = 0;
    mfloor[1] = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    sel6 = 1'b0;
    run_trip(2, 1, 0, 1'b0, 1'b0);
    run_trip(1, 1, 0, 1'b0, 1'b0);
    run_trip(6, 1, 0, 1'b0, 1'b0);
    run_trip(6, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_while_busy();
    sel6 = 1'b0;
    run_trip(3, 1, 0, 1'b1, 1'b1);
    run_trip(0, 2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_door_hold();
    sel6 = 1'b0;
    run_trip(3, 1, 5, 1'b0, 1'b0);
    run_trip(3, 3, 4, 1'b1, 1'b0);
  endtask

  task automatic test_range_err();
    sel6 = 1'b1;
    run_trip(7, 1, 0, 1'b0, 1'b0);
    run_trip(6, 1, 0, 1'b0, 1'b0);
    run_trip(5, 1, 0, 1'b0, 1'b0);
    run_trip(7, 1, 0, 1'b0, 1'b0);
    run_trip(0, 1, 0, 1'b0, 1'b0);
    sel6 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      sel6 = (i % 4 == 3);
      run_trip($urandom_range(0, 7), $urandom_range(1, DT),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    sel6 = 1'b0;
  endtask

  task automatic test_mid_reset();
    sel6 = 1'b0;
    run_trip(0, 1, 0, 1'b0, 1'b0);
    req_floor = 3'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4 * FT) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_floor, a_moving} !== {3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset_floor got fl=%0d mv=%b want 4 1", a_floor, a_moving);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_floor, a_dir, a_moving, a_door, a_arrived, a_err, a_ready} !== {3'd0, 3'b010, 5'b00001}) begin
      n_bad++;
      $display("FAIL async_reset got fl=%0d dir=%b mv=%b dr=%b arr=%b err=%b rdy=%b want 0 010 0 0 0 0 1",
               a_floor, a_dir, a_moving, a_door, a_arrived, a_err, a_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mfloor[0] = 0;
    mfloor[1] = 0;
    @(posedge clk); #1;
    run_trip(3, 1, 0, 1'b0, 1'b0);
    sel6 = 1'b1;
    run_trip(5, 2, 1, 1'b1, 1'b0);
    sel6 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_while_busy();
    test_door_hold();
    test_range_err();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
